// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit_if
// Purpose  : Request/result bundle between issue logic and the mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic [4:0]      rd_in;
  logic            flush;
  logic            busy;
  logic            done;
  logic [4:0]      rd_out;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, opa, opb, rd_in, flush,
    input  busy, done, rd_out, result
  );

  modport slave (
    input  start, op, opa, opb, rd_in, flush,
    output busy, done, rd_out, result
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide, fixed XLEN+2 cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          n_rst,
  muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_op;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_b;
  logic              r_neg_a;
  logic              r_neg_b;
  logic [CW-1:0]     r_cnt;
  logic              r_done;
  logic [4:0]        r_rd_out;
  logic [XLEN-1:0]   r_result;

  logic              w_sign_a;
  logic              w_sign_b;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_accept;
  logic [XLEN-1:0]   w_addend;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_sh;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_res;

  // rs1 signed for MULH/MULHSU/DIV/REM, rs2 signed for MULH/DIV/REM
  assign w_sign_a = (bus.op == 3'b001) || (bus.op == 3'b010) ||
                    (bus.op == 3'b100) || (bus.op == 3'b110);
  assign w_sign_b = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
  assign w_a_neg  = w_sign_a & bus.opa[XLEN-1];
  assign w_b_neg  = w_sign_b & bus.opb[XLEN-1];
  assign w_a_mag  = w_a_neg ? -bus.opa : bus.opa;
  assign w_b_mag  = w_b_neg ? -bus.opb : bus.opb;
  assign w_accept = (r_state == S_IDLE) && bus.start && !bus.flush;

  // Multiply step: {hi,lo} holds partial product over the shifting multiplier
  assign w_addend = r_lo[0] ? r_b : '0;
  assign w_sum    = {1'b0, r_hi} + {1'b0, w_addend};

  // Restoring divide step: {hi,lo} holds partial remainder over the quotient
  assign w_sh     = {r_hi, r_lo[XLEN-1]};
  assign w_ge     = (w_sh >= {1'b0, r_b});
  assign w_diff   = w_sh[XLEN-1:0] - r_b;

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
  assign w_quot     = ((r_neg_a ^ r_neg_b) && (r_b != '0)) ? -r_lo : r_lo;
  assign w_rem      = r_neg_a ? -r_hi : r_hi;

  always_comb begin
    w_fix_res = w_rem;
    case (r_op)
      3'b000:                 w_fix_res = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_res = w_quot;
      default:                w_fix_res = w_rem;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_CALC;
      S_CALC: begin
        if (bus.flush)                      w_next = S_IDLE;
        else if (r_cnt == CW'(XLEN - 1))    w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_op     <= '0;
      r_rd     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_rd_out <= '0;
      r_result <= '0;
    end else begin
      r_done <= (r_state == S_FIX) && !bus.flush;
      if (w_accept) begin
        r_op    <= bus.op;
        r_rd    <= bus.rd_in;
        r_hi    <= '0;
        r_lo    <= w_a_mag;
        r_b     <= w_b_mag;
        r_neg_a <= w_a_neg;
        r_neg_b <= w_b_neg;
        r_cnt   <= '0;
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_op[2]) begin
          r_hi <= w_ge ? w_diff : w_sh[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], w_ge};
        end else begin
          {r_hi, r_lo} <= {w_sum, r_lo[XLEN-1:1]};
        end
      end
      if ((r_state == S_FIX) && !bus.flush) begin
        r_result <= w_fix_res;
        r_rd_out <= r_rd;
      end
    end
  end

  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = r_done;
  assign bus.rd_out = r_rd_out;
  assign bus.result = r_result;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Randomised and directed checks of muldiv_unit against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(32)) bus();

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  // RV32M semantics straight from 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    case (op)
      3'd0: begin p = ua * ub;          return p[31:0];  end
      3'd1: begin p = sa * sb;          return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin p = ua * ub;          return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  // Called on a falling edge; returns on the falling edge after the start edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    bus.rd_in = rd;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    bus.opa   = $urandom;
    bus.opb   = $urandom;
    bus.rd_in = 5'($urandom);
  endtask

  task automatic wait_done(output logic [31:0] res, output logic [4:0] rdo, output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = bus.result;
    rdo = bus.rd_out;
  endtask

  task automatic test_reset;
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    int          seen;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0; bus.opa = '0; bus.opb = '0; bus.rd_in = '0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    checks++;
    if (bus.result !== 32'd0 || bus.rd_out !== 5'd0) begin
      errors++; $display("FAIL reset_data result=%h rd_out=%0d expected 0 0", bus.result, bus.rd_out);
    end
    n_rst = 1'b1;
    @(negedge clk);
    issue(3'd0, 32'd12345, 32'd678, 5'd9);
    wait_done(res, rdo, lat);
    checks++;
    if (res !== ref_model(3'd0, 32'd12345, 32'd678)) begin
      errors++; $display("FAIL reset_preop result=%h expected %h", res, ref_model(3'd0, 32'd12345, 32'd678));
    end
    @(negedge clk);
    issue(3'd4, 32'd1000, 32'd7, 5'd3);
    repeat (8) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid busy=%b done=%b result=%h expected 0 0 0", bus.busy, bus.done, bus.result);
    end
    @(negedge clk);
    n_rst = 1'b1;
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL reset_nodone done_count=%0d expected 0", seen);
    end
  endtask

  task automatic test_mul;
    logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
    logic [31:0] as  [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], 5'(i + 17));
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++; $display("FAIL mul_busy[%0d] busy=%b expected 1", i, bus.busy);
      end
      wait_done(res, rdo, lat);
      checks++;
      if (res !== exp[i] || rdo !== 5'(i + 17) || lat !== 33 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL mul[%0d] result=%h rd=%0d lat=%0d busy=%b expected %h %0d 33 0",
                 i, res, rdo, lat, bus.busy, exp[i], i + 17);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.result !== exp[i]) begin
        errors++; $display("FAIL mul_strobe[%0d] done=%b result=%h expected 0 %h", i, bus.done, bus.result, exp[i]);
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops [8] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
    logic [31:0] as  [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                             32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                             32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], as[i], bs[i], 5'(i));
      wait_done(res, rdo, lat);
      checks++;
      if (res !== exp[i] || rdo !== 5'(i) || lat !== 33) begin
        errors++;
        $display("FAIL div[%0d] result=%h rd=%0d lat=%0d expected %h %0d 33", i, res, rdo, lat, exp[i], i);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    logic [31:0] specials [5] = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF};
    logic [31:0] a, b, res, exp;
    logic [2:0]  op;
    logic [4:0]  rd, rdo;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      rd = 5'($urandom);
      exp = ref_model(op, a, b);
      issue(op, a, b, rd);
      wait_done(res, rdo, lat);
      checks++;
      if (res !== exp || rdo !== rd || lat !== 33) begin
        errors++;
        $display("FAIL rand[%0d] op=%0d a=%h b=%h result=%h rd=%0d lat=%0d expected %h %0d 33",
                 i, op, a, b, res, rdo, lat, exp, rd);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_busy_ignore;
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    int          seen;
    issue(3'd5, 32'd999_999, 32'd37, 5'd11);
    repeat (5) @(negedge clk);
    issue(3'd0, 32'd3, 32'd3, 5'd22);
    wait_done(res, rdo, lat);
    checks++;
    if (res !== ref_model(3'd5, 32'd999_999, 32'd37) || rdo !== 5'd11 || lat + 6 !== 33) begin
      errors++;
      $display("FAIL busy_ignore result=%h rd=%0d lat=%0d expected %h 11 33",
               res, rdo, lat + 6, ref_model(3'd5, 32'd999_999, 32'd37));
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL busy_ignore_extra done_count=%0d expected 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    issue(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd5);
    wait_done(res, rdo, lat);
    checks++;
    if (res !== ref_model(3'd1, 32'hDEAD_BEEF, 32'h1234_5678) || rdo !== 5'd5) begin
      errors++;
      $display("FAIL b2b_first result=%h rd=%0d expected %h 5", res, rdo,
               ref_model(3'd1, 32'hDEAD_BEEF, 32'h1234_5678));
    end
    issue(3'd6, 32'hDEAD_BEEF, 32'd1000, 5'd0);
    wait_done(res, rdo, lat);
    checks++;
    if (res !== ref_model(3'd6, 32'hDEAD_BEEF, 32'd1000) || rdo !== 5'd0 || lat !== 33) begin
      errors++;
      $display("FAIL b2b_second result=%h rd=%0d lat=%0d expected %h 0 33", res, rdo, lat,
               ref_model(3'd6, 32'hDEAD_BEEF, 32'd1000));
    end
    @(negedge clk);
  endtask

  task automatic test_flush;
    logic [31:0] res, prev;
    logic [4:0]  rdo;
    int          lat;
    int          seen;
    issue(3'd3, 32'hCAFE_F00D, 32'h0BAD_CAFE, 5'd7);
    wait_done(res, rdo, lat);
    prev = ref_model(3'd3, 32'hCAFE_F00D, 32'h0BAD_CAFE);
    checks++;
    if (res !== prev) begin
      errors++; $display("FAIL flush_pre result=%h expected %h", res, prev);
    end
    @(negedge clk);
    issue(3'd4, 32'd77777, 32'd3, 5'd9);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.result !== prev || bus.rd_out !== 5'd7) begin
      errors++;
      $display("FAIL flush_calc busy=%b result=%h rd=%0d expected 0 %h 7", bus.busy, bus.result, bus.rd_out, prev);
    end
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL flush_start_idle busy=%b expected 0", bus.busy);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0 || bus.result !== prev) begin
      errors++; $display("FAIL flush_nodone done_count=%0d result=%h expected 0 %h", seen, bus.result, prev);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit. It sits directly downstream of the register file read ports and consumes rdat1/rdat2 as operands. It produces a one-cycle result strobe plus a destination index that drive the register-file write port (wen/wsel/wdat) through the writeback mux. Each operation uses one shift-add or restoring-division engine and takes a fixed latency.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN; verified at 32 only.

Ports:
clk  input  1  rising-edge clock
n_rst  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
opa  input  XLEN  rs1 value (from rdat1)
opb  input  XLEN  rs2 value (from rdat2)
rd_in  input  5  destination register index
flush  input  1  synchronous abort of the in-flight operation
busy  output  1  high while an operation is in flight (CALC or FIX)
done  output  1  one-cycle result-valid strobe (write enable to the register file)
rd_out  output  5  destination index, valid with done
result  output  XLEN  result, valid with done; held until the next done

Behaviour:
- Reset (n_rst=0, asynchronous): state=IDLE, busy=0, done=0, rd_out=0, result=0, all datapath registers=0. Reset mid-operation discards the operation and produces no done.
- States:
  - IDLE: wait for start.
  - CALC: XLEN iterations, one per clock.
  - FIX: sign correction and result select.
- IDLE to CALC on start=1. Latch op and rd_in. Latch operand magnitudes: negate opa if it is treated as signed and is negative; same rule for opb.
  - Signedness: opa is signed for MULH, MULHSU, DIV, REM. opb is signed for MULH, DIV, REM. MUL signedness is irrelevant for the low word.
- CALC:
  - Multiply: 2*XLEN-bit shift-add of the magnitudes.
  - Divide: restoring, unsigned magnitudes, 1 quotient bit per cycle.
  - Counter runs 0..XLEN-1. At count XLEN-1 the state goes to FIX.
- FIX, one cycle:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ (divide-by-zero excluded).
  - Remainder takes the sign of the dividend.
  - Result select: MUL gives product[XLEN-1:0]; MULH/MULHSU/MULHU give product[2XLEN-1:XLEN]; DIV/DIVU give the quotient; REM/REMU give the remainder.
  - On the FIX edge: result and rd_out are registered, done=1, state goes to IDLE.
- Latency: if start is sampled at edge k, busy=1 after edges k..k+32, and done=1 for exactly the cycle after edge k+33, then busy=0. The latency is identical for all ops and operand values.
- done is high in IDLE, so a new start in that cycle is accepted (back-to-back issue, 34-cycle throughput).
- start while busy=1 is ignored; no queuing.
- Divide by zero (opb=0): quotient forced to all ones (DIV and DIVU), remainder = opa unmodified. Same latency, no exception.
- Signed overflow (DIV opa=0x80000000, opb=0xFFFFFFFF): quotient=0x80000000, remainder=0. This follows naturally from the magnitude algorithm; no special case is required.
- flush=1 in CALC or FIX: go to IDLE next edge, busy=0, no done, result unchanged.
  - flush in IDLE has no effect.
  - flush and start in the same IDLE cycle: the start is dropped.
- rd_in=0 is processed normally; done still fires, and the register file discards the write.
- result and rd_out are not cleared after done; only done is a strobe.

Test Plan:
- Reset and idle: assert n_rst=0 mid-CALC of a DIV → busy=0, done=0, result=0 immediately; after release, no done ever appears for that op.
- Multiply: MUL 7×0xFFFFFFFD → result 0xFFFFFFEB, done exactly 34 cycles after start, rd_out equals rd_in.
- High multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF
- Signed divide: DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM 0xFFFFFFF9/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Boundary cases:
  - DIV 5/0 → 0xFFFFFFFF
  - REM 5/0 → 5
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000
  - REM of the same operands → 0
  - All four with standard latency.
- Handshake:
  - start pulsed while busy → ignored; the first op completes with the correct result.
  - start in the done cycle → accepted, second done 34 cycles later.
  - flush at CALC cycle 10 → no done, busy=0 next cycle, prior result retained.
